uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter num_req, default 4, number of byte-stream requesters sharing one simple_tx.
REQ-002 Parameter timeout_max, default 255, stall cycles before a granted requester is forcibly released (timeout build only).
REQ-003 Port _clock  input  1  single clock; all state updates on posedge.
REQ-004 Port _reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port _in  input  num_req x 8  byte from each requester.
REQ-006 Port _in_valid  input  num_req  per-requester byte valid.
REQ-007 Port _in_last  input  num_req  marks final byte of requester's packet.
REQ-008 Port _in_ready  output  num_req  per-requester accept.
REQ-009 Port _out  output  8  byte to transmitter _in.
REQ-010 Port _out_valid  output  1  byte valid to transmitter _in_valid.
REQ-011 Port _out_ready  input  1  transmitter _in_ready.
REQ-012 Port _grant  output  num_req  one-hot current owner; all-zero when idle.
REQ-013 Port _timeout  output  1  one-cycle pulse on forced release.

Function
REQ-014 Two states SHALL exist: IDLE, GRANT.
REQ-015 In IDLE: _out_valid=0, _out=0, _in_ready all 0, _grant all 0.
REQ-016 In IDLE with any _in_valid set, next state SHALL be GRANT, owner = first valid index scanning from ptr upward with wrap at num_req.
REQ-017 Arbitration latency SHALL be exactly one cycle (IDLE cycle seeing valid -> GRANT next cycle).
REQ-018 In GRANT: _out=_in[owner], _out_valid=_in_valid[owner], _in_ready[owner]=_out_ready, all other _in_ready=0.
REQ-019 Byte transfer occurs when _in_valid[owner] && _out_ready in GRANT; non-owner valids SHALL never be accepted.
REQ-020 Transfer with _in_last[owner]=1 SHALL return to IDLE next cycle and set ptr = (owner+1) mod num_req.
REQ-021 Grant SHALL not move to a new owner without one IDLE cycle between packets (one bubble minimum).
REQ-022 Owner withdrawing _in_valid mid-packet SHALL keep the grant (packet atomicity), subject only to REQ-028.
REQ-023 Simultaneous requests: at most one grant; lower priority requesters wait; with all 4 continuously requesting, grants SHALL rotate 0,1,2,3,0.
REQ-024 _in_last without _in_valid SHALL be ignored.

Reset
REQ-025 On _reset_n=0, immediately (asynchronously): state=IDLE, ptr=0, owner=0, stall counter=0, all outputs 0.
REQ-026 Reset mid-packet SHALL drop the packet; no byte of it is presented after reset release.
REQ-027 First cycle after _reset_n rises SHALL behave as IDLE.

Configuration
REQ-028 Macro UART_ARB_TIMEOUT_EN defined: 8-bit stall counter increments each GRANT cycle without a transfer, clears on transfer; reaching timeout_max SHALL force IDLE, advance ptr past owner, pulse _timeout for one cycle.
REQ-029 Macro undefined: no counter, _timeout tied 0, grant held indefinitely until last byte.

Structure
REQ-030 Shared package uart_pkg SHALL hold the state enum (IDLE, GRANT), byte width 8, bits_per_byte 10.
REQ-031 One sub-module round_robin_pick SHALL implement the combinational rotating first-set search (req vector, ptr -> one-hot, any).
REQ-032 Block SHALL connect directly to simple_tx (_out/_out_valid/_out_ready) with no adapter.

Verification
REQ-033 Single requester 1 sends 3 bytes 0x70,0x69,0x6E (last on third), _out_ready=1 -> _grant=0010 one cycle after valid, bytes emitted in order, IDLE after third.
REQ-034 Requesters 0 and 2 valid same cycle from reset -> requester 0 packet completes first, then 1 IDLE cycle, then requester 2.
REQ-035 All 4 requesting single-byte packets continuously -> grant order 0,1,2,3,0,1.
REQ-036 Requester 3 mid-packet, _reset_n pulsed low 2 cycles -> outputs 0 during reset, ptr=0, remaining bytes of the packet not emitted unless re-requested.
REQ-037 UART_ARB_TIMEOUT_EN, timeout_max=10, owner 1 drops valid after first byte -> _timeout pulse after 10 stall cycles, IDLE, next grant goes to 2 if pending.
REQ-038 _out_ready held 0 for 50 cycles with owner valid -> byte held stable on _out, no transfer, no timeout (valid present).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding and byte geometry.
package uart_pkg;

    localparam int byte_w        = 8;
    localparam int bits_per_byte = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/round_robin_pick.sv
// Combinational rotating first-set search: scans req upward from ptr, wrapping at num_req,
// and returns the first set position as a one-hot vector plus an any-request flag.
module round_robin_pick #(
    parameter int num_req = 4,
    parameter int ptr_w   = 2
) (
    input  logic [num_req-1:0] req,
    input  logic [ptr_w-1:0]   ptr,
    output logic [num_req-1:0] pick,
    output logic               any
);

    // One spare bit so ptr + offset cannot wrap before the explicit modulo.
    localparam int sum_w = ptr_w + 1;

    logic [sum_w-1:0] sum;
    logic [ptr_w-1:0] idx;

    // NOTE: every output and temporary gets a value before any branch, so no latch is inferred.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        sum  = '0;
        idx  = '0;
        for (int i = 0; i < num_req; i++) begin
            sum = {1'b0, ptr} + sum_w'(i);
            if (sum >= sum_w'(num_req)) begin
                sum = sum - sum_w'(num_req);
            end
            idx = sum[ptr_w-1:0];
            if (!any && req[idx]) begin
                pick[idx] = 1'b1;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter feeding one simple_tx byte port from num_req requesters.
// Define UART_ARB_TIMEOUT_EN to release an owner that stops offering bytes for timeout_max cycles.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int num_req     = 4,
    parameter int timeout_max = 255
) (
    input  logic                           _clock,
    input  logic                           _reset_n,
    input  logic [num_req-1:0][byte_w-1:0] _in,
    input  logic [num_req-1:0]             _in_valid,
    input  logic [num_req-1:0]             _in_last,
    output logic [num_req-1:0]             _in_ready,
    output logic [byte_w-1:0]              _out,
    output logic                           _out_valid,
    input  logic                           _out_ready,
    output logic [num_req-1:0]             _grant,
    output logic                           _timeout
);

    localparam int ptr_w = (num_req > 1) ? $clog2(num_req) : 1;

    arb_state_e       state_q, state_d;
    logic [ptr_w-1:0] owner_q, owner_d;
    logic [ptr_w-1:0] ptr_q, ptr_d;
    logic [ptr_w-1:0] next_ptr;
    logic [ptr_w-1:0] pick_idx;
    logic [num_req-1:0] pick_oh;
    logic             pick_any;
    logic             xfer;
    logic             force_release;

    round_robin_pick #(
        .num_req (num_req),
        .ptr_w   (ptr_w)
    ) u_pick (
        .req  (_in_valid),
        .ptr  (ptr_q),
        .pick (pick_oh),
        .any  (pick_any)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < num_req; i++) begin
            if (pick_oh[i]) begin
                pick_idx = ptr_w'(i);
            end
        end
    end

    assign next_ptr = (owner_q == ptr_w'(num_req - 1)) ? '0 : owner_q + ptr_w'(1);

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [7:0] stall_limit = 8'(timeout_max - 1);

    logic [7:0] stall_q, stall_d;
    logic       timeout_q, timeout_d;

    // A stall is a granted cycle where the owner offers nothing; back-pressure is not a stall.
    always_comb begin
        stall_d       = '0;
        timeout_d     = 1'b0;
        force_release = 1'b0;
        if (state_q == GRANT && !_in_valid[owner_q]) begin
            if (stall_q == stall_limit) begin
                force_release = 1'b1;
                timeout_d     = 1'b1;
            end else begin
                stall_d = stall_q + 8'd1;
            end
        end
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    assign _timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = |8'(timeout_max);
    assign force_release      = 1'b0;
    assign _timeout           = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        _out      = '0;
        _out_valid = 1'b0;
        _in_ready = '0;
        _grant    = '0;
        xfer      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                end
            end
            GRANT: begin
                _grant[owner_q]    = 1'b1;
                _out               = _in[owner_q];
                _out_valid         = _in_valid[owner_q];
                _in_ready[owner_q] = _out_ready;
                xfer               = _in_valid[owner_q] && _out_ready;
                // Returning through IDLE guarantees the one-cycle bubble between packets.
                if ((xfer && _in_last[owner_q]) || force_release) begin
                    state_d = IDLE;
                    ptr_d   = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, timeout_max 10).
module tb_uart_tx_arbiter;

    logic            clk;
    logic            rst_n;
    logic [3:0][7:0] in_data;
    logic [3:0]      in_valid;
    logic [3:0]      in_last;
    logic [3:0]      in_ready;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      grant;
    logic            timeout;

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(
        .num_req     (4),
        .timeout_max (10)
    ) dut (
        ._clock     (clk),
        ._reset_n   (rst_n),
        ._in        (in_data),
        ._in_valid  (in_valid),
        ._in_last   (in_last),
        ._in_ready  (in_ready),
        ._out       (out_data),
        ._out_valid (out_valid),
        ._out_ready (out_ready),
        ._grant     (grant),
        ._timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    // Tasks start and end just after a falling edge; inputs change only there.
    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_last   = '0;
        in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        out_ready = 1'b1;
        #2;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL reset_out got=%b/%h exp=0/00", out_valid, out_data); end
        checks++; if (in_ready !== 4'b0000 || timeout !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b/%b exp=0000/0", in_ready, timeout); end
        @(negedge clk);
        @(negedge clk);
        in_valid = '0;
        rst_n    = 1'b1;
        #1;
        checks++; if (grant !== 4'b0000 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_idle got=%b/%b exp=0000/0", grant, out_valid); end
    endtask

    task automatic test_single();
        @(negedge clk);
        in_data[1] = 8'h70;
        in_valid   = 4'b0010;
        in_last    = 4'b0000;
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_latency grant=%b exp=0000", grant); end
        @(negedge clk); #1;
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL single_grant got=%b exp=0010", grant); end
        checks++; if (out_data !== 8'h70 || out_valid !== 1'b1) begin errors++; $display("FAIL single_byte0 got=%h/%b exp=70/1", out_data, out_valid); end
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL single_ready got=%b exp=0010", in_ready); end
        @(negedge clk);
        in_data[1] = 8'h69;
        #1;
        checks++; if (out_data !== 8'h69 || grant !== 4'b0010) begin errors++; $display("FAIL single_byte1 got=%h/%b exp=69/0010", out_data, grant); end
        @(negedge clk);
        in_data[1] = 8'h6E;
        in_last    = 4'b0010;
        #1;
        checks++; if (out_data !== 8'h6E || out_valid !== 1'b1) begin errors++; $display("FAIL single_byte2 got=%h/%b exp=6e/1", out_data, out_valid); end
        @(negedge clk);
        in_valid = '0;
        in_last  = '0;
        #1;
        checks++; if (grant !== 4'b0000 || out_valid !== 1'b0) begin errors++; $display("FAIL single_idle got=%b/%b exp=0000/0", grant, out_valid); end
    endtask

    task automatic test_two_requesters();
        do_reset();
        @(negedge clk);
        in_data[0] = 8'hA0;
        in_data[2] = 8'hC0;
        in_valid   = 4'b0101;
        in_last    = 4'b0100;
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL two_latency grant=%b exp=0000", grant); end
        @(negedge clk); #1;
        checks++; if (grant !== 4'b0001 || out_data !== 8'hA0) begin errors++; $display("FAIL two_first got=%b/%h exp=0001/a0", grant, out_data); end
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL two_nonowner_ready got=%b exp=0001", in_ready); end
        @(negedge clk);
        in_data[0] = 8'hA1;
        in_last    = 4'b0101;
        #1;
        checks++; if (grant !== 4'b0001 || out_data !== 8'hA1) begin errors++; $display("FAIL two_first_last got=%b/%h exp=0001/a1", grant, out_data); end
        @(negedge clk);
        in_valid = 4'b0100;
        in_last  = 4'b0100;
        #1;
        checks++; if (grant !== 4'b0000 || out_valid !== 1'b0) begin errors++; $display("FAIL two_bubble got=%b/%b exp=0000/0", grant, out_valid); end
        @(negedge clk); #1;
        checks++; if (grant !== 4'b0100 || out_data !== 8'hC0) begin errors++; $display("FAIL two_second got=%b/%h exp=0100/c0", grant, out_data); end
        @(negedge clk);
        in_valid = '0;
        in_last  = '0;
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL two_end got=%b exp=0000", grant); end
    endtask

    task automatic test_rotation();
        do_reset();
        @(negedge clk);
        in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        in_valid = 4'b1111;
        in_last  = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            logic [3:0] exp_g;
            logic [7:0] exp_b;
            exp_g = 4'b0001 << (k % 4);
            exp_b = 8'(8'h10 + k % 4);
            #1;
            checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rot_bubble_%0d got=%b exp=0000", k, grant); end
            @(negedge clk); #1;
            checks++; if (grant !== exp_g || out_data !== exp_b) begin errors++; $display("FAIL rot_grant_%0d got=%b/%h exp=%b/%h", k, grant, out_data, exp_g, exp_b); end
            @(negedge clk);
        end
        in_valid = '0;
        in_last  = '0;
    endtask

    task automatic test_reset_mid_packet();
        @(negedge clk);
        in_data[3] = 8'hD0;
        in_valid   = 4'b1000;
        in_last    = 4'b0000;
        @(negedge clk); #1;
        checks++; if (grant !== 4'b1000 || out_data !== 8'hD0) begin errors++; $display("FAIL rmid_grant got=%b/%h exp=1000/d0", grant, out_data); end
        @(negedge clk);
        in_data[3] = 8'hD1;
        rst_n      = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000 || in_ready !== 4'b0000) begin errors++; $display("FAIL rmid_async got=%b/%b exp=0000/0000", grant, in_ready); end
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL rmid_out got=%b/%h exp=0/00", out_valid, out_data); end
        in_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (grant !== 4'b0000 || out_valid !== 1'b0) begin errors++; $display("FAIL rmid_first_idle got=%b/%b exp=0000/0", grant, out_valid); end
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL rmid_dropped got=%b/%h exp=0/00", out_valid, out_data); end
        in_data[1] = 8'hB1;
        in_data[3] = 8'hD2;
        in_valid   = 4'b1010;
        in_last    = 4'b1010;
        @(negedge clk); #1;
        checks++; if (grant !== 4'b0010 || out_data !== 8'hB1) begin errors++; $display("FAIL rmid_ptr_zero got=%b/%h exp=0010/b1", grant, out_data); end
        @(negedge clk);
        in_valid = 4'b1000;
        @(negedge clk); #1;
        checks++; if (grant !== 4'b1000 || out_data !== 8'hD2) begin errors++; $display("FAIL rmid_rerequest got=%b/%h exp=1000/d2", grant, out_data); end
        @(negedge clk);
        in_valid = '0;
        in_last  = '0;
    endtask

    task automatic test_withdraw();
        do_reset();
        @(negedge clk);
        in_data[0] = 8'hA5;
        in_data[1] = 8'hB5;
        in_valid   = 4'b0011;
        in_last    = 4'b0000;
        @(negedge clk); #1;
        checks++; if (grant !== 4'b0001 || in_ready !== 4'b0001) begin errors++; $display("FAIL wd_grant got=%b/%b exp=0001/0001", grant, in_ready); end
        @(negedge clk);
        in_valid = 4'b0010;
        in_last  = 4'b0011;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (grant !== 4'b0001 || out_valid !== 1'b0 || in_ready[1] !== 1'b0) begin errors++; $display("FAIL wd_hold_%0d got=%b/%b/%b exp=0001/0/0", c, grant, out_valid, in_ready); end
            @(negedge clk);
        end
        in_data[0] = 8'hA6;
        in_valid   = 4'b0011;
        in_last    = 4'b0001;
        #1;
        checks++; if (grant !== 4'b0001 || out_data !== 8'hA6) begin errors++; $display("FAIL wd_resume got=%b/%h exp=0001/a6", grant, out_data); end
        @(negedge clk);
        in_valid = 4'b0010;
        in_last  = 4'b0010;
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL wd_bubble got=%b exp=0000", grant); end
        @(negedge clk); #1;
        checks++; if (grant !== 4'b0010 || out_data !== 8'hB5) begin errors++; $display("FAIL wd_next got=%b/%h exp=0010/b5", grant, out_data); end
        @(negedge clk);
        in_valid = '0;
        in_last  = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        in_data[0] = 8'hC3;
        in_valid   = 4'b0001;
        in_last    = 4'b0001;
        out_ready  = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 50; c++) begin
            #1;
            checks++;
            if ({grant, out_data, out_valid, in_ready, timeout} !== {4'b0001, 8'hC3, 1'b1, 4'b0000, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold_%0d got=%b/%h/%b/%b/%b exp=0001/c3/1/0000/0", c, grant, out_data, out_valid, in_ready, timeout);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL bp_release got=%b exp=0001", in_ready); end
        @(negedge clk);
        in_valid = '0;
        in_last  = '0;
        #1;
        checks++; if (grant !== 4'b0000 || timeout !== 1'b0) begin errors++; $display("FAIL bp_done got=%b/%b exp=0000/0", grant, timeout); end
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        @(negedge clk);
        in_data[1] = 8'hB7;
        in_data[2] = 8'hC7;
        in_valid   = 4'b0110;
        in_last    = 4'b0100;
        @(negedge clk); #1;
        checks++; if (grant !== 4'b0010 || out_data !== 8'hB7) begin errors++; $display("FAIL to_grant got=%b/%h exp=0010/b7", grant, out_data); end
        @(negedge clk);
        in_valid = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++; if (grant !== 4'b0010 || timeout !== 1'b0) begin errors++; $display("FAIL to_stall_%0d got=%b/%b exp=0010/0", c, grant, timeout); end
            @(negedge clk);
        end
        #1;
        checks++; if (grant !== 4'b0000 || timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got=%b/%b exp=0000/1", grant, timeout); end
        @(negedge clk); #1;
        checks++; if (grant !== 4'b0100 || timeout !== 1'b0 || out_data !== 8'hC7) begin errors++; $display("FAIL to_next got=%b/%b/%h exp=0100/0/c7", grant, timeout, out_data); end
        @(negedge clk);
        in_valid = '0;
        in_last  = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_two_requesters();
        test_rotation();
        test_reset_mid_packet();
        test_withdraw();
        test_backpressure();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
